instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/ti170_isa_pkg.sv | 38 +++
 rtl/ifu_len_decode.sv | 13 +
 rtl/instruction_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ti170_isa_pkg.sv
// TI170 ISA shared definitions: opcode constants, fetch FSM states and the
// instruction-length helpers used by both fetch and decode.
package ti170_isa_pkg;

  localparam logic [7:0] LDA_IMM = 8'h86;
  localparam logic [7:0] LDA_DIR = 8'h87;
  localparam logic [7:0] LDB_IMM = 8'h88;
  localparam logic [7:0] LDB_DIR = 8'h89;
  localparam logic [7:0] STA_DIR = 8'h96;
  localparam logic [7:0] STB_DIR = 8'h97;
  localparam logic [7:0] ADD_AB  = 8'h42;
  localparam logic [7:0] JMP     = 8'h20;
  localparam logic [7:0] BEQ     = 8'h23;

  typedef enum logic [2:0] {
    S_ADDR,
    S_OP,
    S_OPND,
    S_ISSUE,
    S_FAULT
  } ifu_state_e;

  // Undefined opcodes are treated as single-byte instructions.
  function automatic logic [1:0] instr_len(input logic [7:0] opcode);
    case (opcode)
      LDA_IMM, LDA_DIR, LDB_IMM, LDB_DIR, STA_DIR, STB_DIR, JMP, BEQ: instr_len = 2'd2;
      default: instr_len = 2'd1;
    endcase
  endfunction

  function automatic logic instr_defined(input logic [7:0] opcode);
    case (opcode)
      LDA_IMM, LDA_DIR, LDB_IMM, LDB_DIR, STA_DIR, STB_DIR, JMP, BEQ, ADD_AB: instr_defined = 1'b1;
      default: instr_defined = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ifu_len_decode.sv
// Opcode length decoder: byte count of an instruction and whether the opcode is defined.
module ifu_len_decode
  import ti170_isa_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] length,
  output logic       defined
);

  assign length  = instr_len(opcode);
  assign defined = instr_defined(opcode);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: reads opcode/operand bytes from a 1-cycle-latency ROM and
// hands them to decode. Define IFU_BOUNDS_CHECK_EN to trap fetches beyond ROM_LAST.
module instruction_fetch_unit
  import ti170_isa_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [7:0] ROM_LAST = 8'd127
) (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic       halt,
  input  logic       redirect_valid,
  input  logic [7:0] redirect_target,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] instr_opcode,
  output logic [7:0] instr_operand,
  output logic [7:0] instr_pc,
  output logic       fault
);

`ifdef IFU_BOUNDS_CHECK_EN
  localparam bit BoundsEn = 1'b1;
`else
  localparam bit BoundsEn = 1'b0;
`endif

  ifu_state_e state_q;
  logic [7:0] pc_q;
  logic [7:0] pc_inc;
  logic [8:0] pc_sum;
  logic [1:0] len_q;
  logic [1:0] dec_len;
  logic [1:0] op_len;
  logic       dec_defined;
  logic       valid_q;
  logic       fault_q;
  logic [7:0] opcode_q;
  logic [7:0] operand_q;
  logic [7:0] ipc_q;
  logic       addr_oob;
  logic       opnd_oob;
  logic       issue_wrap;

  ifu_len_decode u_len_decode (
    .opcode  (rom_data),
    .length  (dec_len),
    .defined (dec_defined)
  );

  assign op_len = dec_defined ? dec_len : 2'd1;
  assign pc_inc = pc_q + 8'd1;
  assign pc_sum = {1'b0, pc_q} + {7'd0, len_q};

  // Fault conditions only ever fire when bounds checking is built in.
  assign addr_oob   = BoundsEn && (pc_q > ROM_LAST);
  assign opnd_oob   = BoundsEn && (op_len == 2'd2) && ((pc_q == 8'hFF) || (pc_inc > ROM_LAST));
  assign issue_wrap = BoundsEn && pc_sum[8];

  always_comb begin
    rom_addr = pc_q;
    if (reset) begin
      rom_addr = RESET_PC;
    end else if ((state_q == S_OP) || (state_q == S_OPND)) begin
      rom_addr = pc_inc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_ADDR;
      pc_q      <= RESET_PC;
      len_q     <= 2'd1;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      opcode_q  <= 8'h00;
      operand_q <= 8'h00;
      ipc_q     <= 8'h00;
    end else if (redirect_valid && (state_q != S_FAULT)) begin
      // Redirect wins over halt, partial fetches and the sequential PC update.
      state_q <= S_ADDR;
      pc_q    <= redirect_target;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_ADDR: begin
          if (!halt) begin
            if (addr_oob) begin
              state_q <= S_FAULT;
              fault_q <= 1'b1;
            end else begin
              state_q <= S_OP;
            end
          end
        end
        S_OP: begin
          if (opnd_oob) begin
            state_q <= S_FAULT;
            fault_q <= 1'b1;
          end else begin
            opcode_q <= rom_data;
            ipc_q    <= pc_q;
            len_q    <= op_len;
            if (op_len == 2'd2) begin
              state_q <= S_OPND;
            end else begin
              operand_q <= 8'h00;
              valid_q   <= 1'b1;
              state_q   <= S_ISSUE;
            end
          end
        end
        S_OPND: begin
          operand_q <= rom_data;
          valid_q   <= 1'b1;
          state_q   <= S_ISSUE;
        end
        S_ISSUE: begin
          if (instr_ready) begin
            valid_q <= 1'b0;
            if (issue_wrap) begin
              state_q <= S_FAULT;
              fault_q <= 1'b1;
            end else begin
              pc_q    <= pc_sum[7:0];
              state_q <= S_ADDR;
            end
          end
        end
        S_FAULT: state_q <= S_FAULT;
        default: state_q <= S_ADDR;
      endcase
    end
  end

  assign instr_valid   = valid_q;
  assign instr_opcode  = opcode_q;
  assign instr_operand = operand_q;
  assign instr_pc      = ipc_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed vectors, corner sequences and a
// randomized run against a program-walk reference model. Honours IFU_BOUNDS_CHECK_EN.
module tb_instruction_fetch_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       halt;
  logic       redirect_valid;
  logic [7:0] redirect_target;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_opcode;
  logic [7:0] instr_operand;
  logic [7:0] instr_pc;
  logic       fault;

  logic [7:0] rom [256];
  logic [7:0] two_byte [8];

  int checks = 0;
  int failures = 0;

  instruction_fetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .halt            (halt),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_opcode    (instr_opcode),
    .instr_operand   (instr_operand),
    .instr_pc        (instr_pc),
    .fault           (fault)
  );

  always #5 clock = ~clock;

  // Synchronous ROM: data for the address sampled on an edge appears after that edge.
  always @(posedge clock) rom_data <= rom[rom_addr];

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] op;
    logic [7:0] opnd;
    logic [7:0] lat;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Count edges until instr_valid is seen; -1 if it never comes within the budget.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!instr_valid && lat < 12) begin
      tick();
      lat++;
    end
    if (!instr_valid) lat = -1;
  endtask

  // Leaves the DUT parked (halted) at the new PC.
  task automatic jump_to(input logic [7:0] target);
    halt = 1'b1;
    instr_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic accept();
    halt = 1'b1;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  function automatic int model_len(input logic [7:0] op);
    for (int k = 0; k < 8; k++) if (two_byte[k] == op) return 2;
    return 1;
  endfunction

  initial begin
    int lat;
    int ml;
    int nhs;
    logic [7:0] mpc;
    logic [7:0] nxt;
    logic [7:0] tmp;
    logic [24:0] snap;
    logic hold;

    two_byte = '{8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97, 8'h20, 8'h23};
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[0] = 8'h86; rom[1] = 8'hAA; rom[2] = 8'h96;
    rom[3] = 8'hE0; rom[4] = 8'h20; rom[5] = 8'h00;

    vecs[0]  = '{8'h10, 8'h42, 8'h86, 8'h42, 8'h00, 8'd2};
    vecs[1]  = '{8'h14, 8'h86, 8'hAA, 8'h86, 8'hAA, 8'd3};
    vecs[2]  = '{8'h18, 8'h87, 8'h01, 8'h87, 8'h01, 8'd3};
    vecs[3]  = '{8'h1C, 8'h88, 8'h02, 8'h88, 8'h02, 8'd3};
    vecs[4]  = '{8'h20, 8'h89, 8'h03, 8'h89, 8'h03, 8'd3};
    vecs[5]  = '{8'h24, 8'h96, 8'hE0, 8'h96, 8'hE0, 8'd3};
    vecs[6]  = '{8'h28, 8'h97, 8'hE1, 8'h97, 8'hE1, 8'd3};
    vecs[7]  = '{8'h2C, 8'h20, 8'h04, 8'h20, 8'h04, 8'd3};
    vecs[8]  = '{8'h30, 8'h23, 8'h05, 8'h23, 8'h05, 8'd3};
    vecs[9]  = '{8'h34, 8'h00, 8'h99, 8'h00, 8'h00, 8'd2};
    vecs[10] = '{8'h38, 8'hFF, 8'h11, 8'hFF, 8'h00, 8'd2};
    vecs[11] = '{8'h3C, 8'h43, 8'h22, 8'h43, 8'h00, 8'd2};

    reset = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_target = 8'h00;
    instr_ready = 1'b1;
    #1;
    check("reset_rom_addr", rom_addr, 8'h00);
    tick(); tick();
    check("reset_outputs", {instr_valid, instr_opcode, instr_operand, instr_pc, fault}, 0);

    // Program 86 AA 96 E0 20 00 with decode always ready.
    reset = 1'b0;
    tick(); tick();
    check("first_opcode_2cyc", {instr_valid, instr_opcode}, {1'b0, 8'h86});
    tick();
    check("prog0_fields", {instr_valid, instr_opcode, instr_operand, instr_pc}, {1'b1, 24'h86AA00});
    tick();
    wait_valid(lat);
    check("prog1_lat", lat, 3);
    check("prog1_fields", {instr_opcode, instr_operand, instr_pc}, 24'h96E002);
    tick();
    wait_valid(lat);
    check("prog2_lat", lat, 3);
    check("prog2_fields", {instr_opcode, instr_operand, instr_pc}, 24'h200004);
    accept();
    check("prog_end_addr", {instr_valid, rom_addr}, {1'b0, 8'h06});

    // Reset in the middle of a fetch.
    halt = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("midfetch_reset_addr", rom_addr, 8'h00);
    tick();
    check("midfetch_reset_out", {instr_valid, instr_opcode, instr_operand, instr_pc, fault}, 0);
    halt = 1'b1;
    reset = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      tmp = vecs[i].pc + 8'd1;
      rom[vecs[i].pc] = vecs[i].b0;
      rom[tmp] = vecs[i].b1;
      jump_to(vecs[i].pc);
      halt = 1'b0;
      wait_valid(lat);
      check($sformatf("vec%0d_lat", i), lat, 32'(vecs[i].lat));
      check($sformatf("vec%0d_fields", i), {instr_opcode, instr_operand, instr_pc},
            {vecs[i].op, vecs[i].opnd, vecs[i].pc});
      accept();
      check($sformatf("vec%0d_next_pc", i), rom_addr, vecs[i].pc + vecs[i].lat - 8'd1);
    end

    // Decode stalls for five cycles.
    rom[8'h50] = 8'h88; rom[8'h51] = 8'h33;
    jump_to(8'h50);
    halt = 1'b0;
    wait_valid(lat);
    check("stall_lat", lat, 3);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_hold%0d", i),
            {instr_valid, instr_opcode, instr_operand, instr_pc, rom_addr}, {1'b1, 32'h88335050});
      tick();
    end
    accept();
    check("stall_advance", {instr_valid, rom_addr}, {1'b0, 8'h52});

    // Halt in S_ADDR, then a redirect while halted.
    for (int i = 0; i < 3; i++) begin
      check($sformatf("halt_hold%0d", i), {instr_valid, rom_addr}, {1'b0, 8'h52});
      tick();
    end
    rom[8'h44] = 8'h97; rom[8'h45] = 8'h5C;
    redirect_valid = 1'b1; redirect_target = 8'h44;
    tick();
    redirect_valid = 1'b0;
    check("halt_redirect_pc", {instr_valid, rom_addr}, {1'b0, 8'h44});
    tick();
    check("halt_still_blocks", {instr_valid, rom_addr}, {1'b0, 8'h44});
    halt = 1'b0;
    wait_valid(lat);
    check("halt_release_lat", lat, 3);
    check("halt_release_fields", {instr_opcode, instr_operand, instr_pc}, 24'h975C44);
    accept();

    // Redirect while the operand byte is being fetched.
    rom[8'h60] = 8'h86; rom[8'h61] = 8'h11; rom[8'h40] = 8'h42;
    jump_to(8'h60);
    halt = 1'b0;
    tick(); tick();
    check("opnd_addr", {instr_valid, rom_addr}, {1'b0, 8'h61});
    redirect_valid = 1'b1; redirect_target = 8'h40;
    tick();
    redirect_valid = 1'b0;
    check("redir_addr", {instr_valid, rom_addr}, {1'b0, 8'h40});
    wait_valid(lat);
    check("redir_lat", lat, 2);
    check("redir_fields", {instr_opcode, instr_operand, instr_pc}, 24'h420040);
    accept();

    // Two-byte opcode at the last ROM address.
    rom[8'h7F] = 8'h86; rom[8'h80] = 8'h3C; rom[8'hFF] = 8'h42;
    jump_to(8'h7F);
    halt = 1'b0;
    wait_valid(lat);
`ifdef IFU_BOUNDS_CHECK_EN
    check("oob_no_issue", lat, -1);
    check("oob_fault", {fault, instr_valid}, 2'b10);
    redirect_valid = 1'b1; redirect_target = 8'h10;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("oob_sticky", {fault, instr_valid, rom_addr}, {2'b10, 8'h7F});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("oob_reset_clears", {fault, instr_valid}, 2'b00);
`else
    check("edge_lat", lat, 3);
    check("edge_fields", {fault, instr_opcode, instr_operand, instr_pc}, {1'b0, 24'h863C7F});
    accept();
    check("edge_next_pc", rom_addr, 8'h81);
    jump_to(8'hFF);
    halt = 1'b0;
    wait_valid(lat);
    check("wrap_lat", lat, 2);
    check("wrap_fields", {instr_opcode, instr_operand, instr_pc}, 24'h4200FF);
    accept();
    check("wrap_next_pc", {fault, rom_addr}, {1'b0, 8'h00});
`endif

    // Randomized run: the model walks the ROM image instruction by instruction.
    for (int i = 0; i < 256; i++)
      rom[i] = ($urandom_range(0, 1) == 1) ? two_byte[$urandom_range(0, 7)] : 8'($urandom);
    reset = 1'b1; halt = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
    tick();
    reset = 1'b0;
    mpc = 8'h00; hold = 1'b0; nhs = 0; snap = '0;
    for (int c = 0; c < 3000; c++) begin
      halt = ($urandom_range(0, 3) == 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      redirect_valid = (mpc >= 8'h70) || ($urandom_range(0, 24) == 0);
      redirect_target = 8'($urandom_range(0, 8'h5F));
      if (hold) check("rand_hold", {instr_valid, instr_opcode, instr_operand, instr_pc}, snap);
      hold = 1'b0;
      ml = model_len(rom[mpc]);
      nxt = mpc + 8'd1;
      if (instr_valid && instr_ready) begin
        check("rand_issue", {instr_opcode, instr_operand, instr_pc},
              {rom[mpc], (ml == 2) ? rom[nxt] : 8'h00, mpc});
        nhs++;
      end else if (instr_valid && !redirect_valid) begin
        hold = 1'b1;
        snap = {1'b1, instr_opcode, instr_operand, instr_pc};
      end
      if (redirect_valid) mpc = redirect_target;
      else if (instr_valid && instr_ready) mpc = mpc + 8'(ml);
      tick();
    end
    redirect_valid = 1'b0;
    check("rand_handshakes", (nhs > 100), 1);
    check("rand_no_fault", fault, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
